// File: rtl/sd_request_arbiter.sv
// -----------------------------------------------------------------------------
// sd_request_arbiter
//
// Sits in front of sd_card_controller. Waits for the controller's power-up
// initialisation (busy high then low), then grants single-block READ/WRITE
// operations to two requesters in round-robin order. While an operation runs
// it forwards read bytes to the requesters, muxes the owner's write byte to
// the controller, and reports completion (done) or a watchdog timeout.
//
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   req_valid[1:0]         per-requester pending operation (held until accepted)
//   req_op[1:0]            per-requester op: 0 = READ, 1 = WRITE
//   req_addr[63:0]         [32n+31:32n] block address of requester n
//   req_wdata[15:0]        [8n+7:8n] write byte of requester n
//   req_accept[1:0]        one-cycle pulse on the granted requester bit
//   grant_id               owner of the current / most recent operation
//   rd_data, rd_valid      read byte and its one-cycle strobe
//   rd_index[8:0]          index (0..511) of the byte on rd_data
//   done                   one-cycle pulse when an operation completes
//   timeout_err            one-cycle pulse when an operation times out
//   fault                  sticky timeout flag, cleared only by rst
//   ready                  card initialised and arbiter idle
//   sd_execute, sd_op_code, sd_block_address, sd_outgoing_byte
//                          controller command / write data
//   sd_busy, sd_finished_byte, sd_finished_block, sd_incoming_byte
//                          controller status / read data
// -----------------------------------------------------------------------------
module sd_request_arbiter #(
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_accept,
    output logic        grant_id,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [8:0]  rd_index,
    output logic        done,
    output logic        timeout_err,
    output logic        fault,
    output logic        ready,
    output logic        sd_execute,
    output logic        sd_op_code,
    output logic [31:0] sd_block_address,
    output logic [7:0]  sd_outgoing_byte,
    input  logic        sd_busy,
    input  logic        sd_finished_byte,
    input  logic        sd_finished_block,
    input  logic [7:0]  sd_incoming_byte
);

    // Timer is wide enough to hold TIMEOUT_CYCLES itself, so the increment
    // on the expiring cycle can never wrap.
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT_WAIT_BUSY,
        INIT_WAIT_IDLE,
        IDLE,
        ISSUE,
        ACTIVE,
        DRAIN,
        FAULT
    } state_t;

    state_t           state;
    state_t           state_next;

    logic             last_grant;
    logic             op_write;
    logic [8:0]       byte_count;
    logic [TMR_W-1:0] timer;

    logic             grant_en;
    logic             grant_sel;
    logic             take_byte;
    logic             take_block;
    logic             expire;
    logic             tmr_last;

    assign tmr_last = (timer == TMR_LAST);

    // Write data follows the owner combinationally; the requester paces its
    // own byte stream against sd_finished_byte.
    assign sd_outgoing_byte = grant_id ? req_wdata[15:8] : req_wdata[7:0];

    // ---- state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT_WAIT_BUSY;
        end else begin
            state <= state_next;
        end
    end

    // ---- next-state and per-cycle decisions ----
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        grant_sel  = 1'b0;
        take_byte  = 1'b0;
        take_block = 1'b0;
        expire     = 1'b0;

        case (state)
            INIT_WAIT_BUSY: begin
                if (sd_busy) state_next = INIT_WAIT_IDLE;
            end

            INIT_WAIT_IDLE: begin
                if (!sd_busy) state_next = IDLE;
            end

            IDLE: begin
                if (|req_valid) begin
                    grant_en = 1'b1;
                    // Under contention alternate away from the last owner;
                    // otherwise the single pending requester wins.
                    if (&req_valid) grant_sel = ~last_grant;
                    else            grant_sel = req_valid[1];
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (tmr_last) begin
                    expire     = 1'b1;
                    state_next = FAULT;
                end else if (sd_busy) begin
                    state_next = ACTIVE;
                end
            end

            ACTIVE: begin
                take_byte = sd_finished_byte && !op_write;
                // Completion wins over a timeout landing on the same cycle.
                if (sd_finished_block) begin
                    take_block = 1'b1;
                    state_next = DRAIN;
                end else if (tmr_last) begin
                    expire     = 1'b1;
                    state_next = FAULT;
                end
            end

            DRAIN: begin
                if (!sd_busy) state_next = IDLE;
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = INIT_WAIT_BUSY;
            end
        endcase
    end

    // ---- registered outputs and operation context ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_accept       <= 2'b00;
            grant_id         <= 1'b0;
            last_grant       <= 1'b1;
            op_write         <= 1'b0;
            rd_data          <= 8'h00;
            rd_valid         <= 1'b0;
            rd_index         <= 9'd0;
            byte_count       <= 9'd0;
            done             <= 1'b0;
            timeout_err      <= 1'b0;
            fault            <= 1'b0;
            ready            <= 1'b0;
            sd_execute       <= 1'b0;
            sd_op_code       <= 1'b0;
            sd_block_address <= 32'h0000_0000;
            timer            <= '0;
        end else begin
            req_accept  <= 2'b00;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            ready       <= (state_next == IDLE);

            if (grant_en) begin
                req_accept       <= grant_sel ? 2'b10 : 2'b01;
                grant_id         <= grant_sel;
                last_grant       <= grant_sel;
                op_write         <= req_op[grant_sel];
                sd_op_code       <= req_op[grant_sel];
                sd_block_address <= grant_sel ? req_addr[63:32] : req_addr[31:0];
                sd_execute       <= 1'b1;
                rd_index         <= 9'd0;
                byte_count       <= 9'd0;
                timer            <= '0;
            end

            if (state == ISSUE || state == ACTIVE) begin
                timer <= timer + TMR_W'(1);
            end

            // Controller has latched the command once it reports busy.
            if (state == ISSUE && state_next == ACTIVE) begin
                sd_execute <= 1'b0;
            end

            // rd_index presents the index of the byte being strobed out;
            // byte_count holds the index of the next one (wraps 511 -> 0).
            if (take_byte) begin
                rd_valid   <= 1'b1;
                rd_data    <= sd_incoming_byte;
                rd_index   <= byte_count;
                byte_count <= byte_count + 9'd1;
            end

            if (take_block) begin
                done <= 1'b1;
            end

            if (expire) begin
                timeout_err <= 1'b1;
                fault       <= 1'b1;
                sd_execute  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sd_request_arbiter
//
// Directed stimulus drives a simple controller model; every expected grant,
// read byte, completion and timeout is pushed into a queue when issued, and a
// negedge monitor pops and compares whenever the DUT strobes that output.
// A second instance with a short watchdog covers the timeout path.
// -----------------------------------------------------------------------------
module tb_sd_request_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        rst_t = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_valid_t = 2'b00;
    logic [1:0]  req_op = 2'b00;
    logic [63:0] req_addr = 64'd0;
    logic [15:0] req_wdata = 16'd0;
    logic        sd_busy = 1'b0;
    logic        sd_busy_t = 1'b0;
    logic        sd_finished_byte = 1'b0;
    logic        sd_finished_block = 1'b0;
    logic [7:0]  sd_incoming_byte = 8'h00;

    logic [1:0]  req_accept, req_accept_t;
    logic        grant_id, grant_id_t;
    logic [7:0]  rd_data, rd_data_t;
    logic        rd_valid, rd_valid_t;
    logic [8:0]  rd_index, rd_index_t;
    logic        done, done_t;
    logic        timeout_err, timeout_err_t;
    logic        fault, fault_t;
    logic        ready, ready_t;
    logic        sd_execute, sd_execute_t;
    logic        sd_op_code, sd_op_code_t;
    logic [31:0] sd_block_address, sd_block_address_t;
    logic [7:0]  sd_outgoing_byte, sd_outgoing_byte_t;

    sd_request_arbiter #(.TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .grant_id(grant_id),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_index(rd_index),
        .done(done), .timeout_err(timeout_err), .fault(fault), .ready(ready),
        .sd_execute(sd_execute), .sd_op_code(sd_op_code),
        .sd_block_address(sd_block_address), .sd_outgoing_byte(sd_outgoing_byte),
        .sd_busy(sd_busy), .sd_finished_byte(sd_finished_byte),
        .sd_finished_block(sd_finished_block), .sd_incoming_byte(sd_incoming_byte)
    );

    sd_request_arbiter #(.TIMEOUT_CYCLES(50)) dut_t (
        .clk(clk), .rst(rst_t),
        .req_valid(req_valid_t), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept_t), .grant_id(grant_id_t),
        .rd_data(rd_data_t), .rd_valid(rd_valid_t), .rd_index(rd_index_t),
        .done(done_t), .timeout_err(timeout_err_t), .fault(fault_t), .ready(ready_t),
        .sd_execute(sd_execute_t), .sd_op_code(sd_op_code_t),
        .sd_block_address(sd_block_address_t), .sd_outgoing_byte(sd_outgoing_byte_t),
        .sd_busy(sd_busy_t), .sd_finished_byte(1'b0),
        .sd_finished_block(1'b0), .sd_incoming_byte(8'h00)
    );

    typedef struct packed {
        logic [1:0]  acc;
        logic [31:0] addr;
        logic        op;
        logic        gid;
    } acc_exp_t;

    acc_exp_t    acc_q[$];
    acc_exp_t    acc_t_q[$];
    logic [16:0] rd_q[$];
    logic        done_q[$];
    int          to_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- scoreboard monitor ----
    always @(negedge clk) begin : monitor
        acc_exp_t    ea;
        logic [16:0] er;
        logic        eg;
        int          ec;
        if (req_accept != 2'b00) begin
            if (acc_q.size() == 0) begin
                chk("accept_unexpected", 64'(req_accept), 64'd0);
            end else begin
                ea = acc_q.pop_front();
                chk("accept_bits", 64'(req_accept), 64'(ea.acc));
                chk("accept_addr", 64'(sd_block_address), 64'(ea.addr));
                chk("accept_op", 64'(sd_op_code), 64'(ea.op));
                chk("accept_gid", 64'(grant_id), 64'(ea.gid));
                chk("accept_exec", 64'(sd_execute), 64'd1);
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                er = rd_q.pop_front();
                chk("rd_byte", 64'({rd_index, rd_data}), 64'(er));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'd0);
            end else begin
                eg = done_q.pop_front();
                chk("done_gid", 64'(grant_id), 64'(eg));
            end
        end
        if (timeout_err) chk("timeout_unexpected", 64'(timeout_err), 64'd0);

        if (req_accept_t != 2'b00) begin
            if (acc_t_q.size() == 0) begin
                chk("t_accept_unexpected", 64'(req_accept_t), 64'd0);
            end else begin
                ea = acc_t_q.pop_front();
                chk("t_accept_bits", 64'(req_accept_t), 64'(ea.acc));
                chk("t_accept_addr", 64'(sd_block_address_t), 64'(ea.addr));
            end
        end
        if (timeout_err_t) begin
            if (to_q.size() == 0) begin
                chk("t_timeout_unexpected", 64'(timeout_err_t), 64'd0);
            end else begin
                ec = to_q.pop_front();
                chk("timeout_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // Controller model for one granted operation. Enters with the grant due
    // (or already made); leaves with the DUT back in IDLE.
    task automatic serve_op(input logic is_read, input int nbytes, input logic gid,
                            input int exp_wait, input logic [1:0] hold_valid,
                            input logic [7:0] wbyte);
        int waited = 0;
        while (!sd_execute && waited < 8) begin
            tick();
            waited++;
        end
        chk("exec_latency", 64'(waited), 64'(exp_wait));
        req_valid        = hold_valid;
        sd_busy          = 1'b1;
        sd_finished_byte = 1'b1;     // stray pulse while still in ISSUE
        sd_incoming_byte = 8'hEE;
        tick();
        sd_finished_byte = 1'b0;
        chk("exec_dropped", 64'(sd_execute), 64'd0);
        if (!is_read) chk("wr_byte_mux", 64'(sd_outgoing_byte), 64'(wbyte));
        for (int i = 0; i < nbytes; i++) begin
            sd_finished_byte = 1'b1;
            sd_incoming_byte = i[7:0];
            if (is_read) rd_q.push_back({i[8:0], i[7:0]});
            if (is_read && i == nbytes - 1) begin
                sd_finished_block = 1'b1;
                done_q.push_back(gid);
            end
            tick();
        end
        sd_finished_byte = 1'b0;
        if (is_read && nbytes > 0) begin
            chk("done_with_last_byte", 64'({done, rd_valid}), 64'd3);
        end else begin
            sd_finished_block = 1'b1;
            done_q.push_back(gid);
            tick();
        end
        sd_finished_block = 1'b0;
        sd_busy = 1'b0;
        tick();
    endtask

    task automatic reset_init();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sd_busy = 1'b0;
        tick();
        sd_busy = 1'b1;
        tick();
        tick();
        sd_busy = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        logic g;

        #2;
        rst   = 1'b1;
        rst_t = 1'b1;
        tick();

        // ---- reset values ----
        chk("reset_pulses", 64'({req_accept, rd_valid, done, timeout_err}), 64'd0);
        chk("reset_sd_ctrl", 64'({sd_execute, sd_op_code, sd_block_address}), 64'd0);
        chk("reset_rd", 64'({rd_data, rd_index}), 64'd0);
        chk("reset_status", 64'({grant_id, fault, ready}), 64'd0);

        // ---- init gating + 512-byte read for requester 0 ----
        rst       = 1'b0;
        req_addr  = {32'h0000_2222, 32'h0000_0010};
        req_op    = 2'b00;
        req_valid = 2'b01;
        repeat (5) tick();
        chk("init_ready_pre_busy", 64'(ready), 64'd0);
        sd_busy = 1'b1;
        repeat (100) tick();
        chk("init_no_accept_busy", 64'({ready, req_accept}), 64'd0);
        sd_busy = 1'b0;
        acc_q.push_back({2'b01, 32'h0000_0010, 1'b0, 1'b0});
        tick();
        chk("init_ready", 64'(ready), 64'd1);
        chk("init_accept_wait", 64'(req_accept), 64'd0);
        tick();
        chk("init_accept", 64'(req_accept), 64'd1);
        serve_op(1'b1, 512, 1'b0, 0, 2'b00, 8'h00);
        chk("read_ready_after", 64'(ready), 64'd1);

        // ---- contention: fresh reset, grants 0,1,0,1 ----
        reset_init();
        chk("cont_ready", 64'(ready), 64'd1);
        req_addr  = {32'hBBBB_0002, 32'hAAAA_0001};
        req_op    = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            acc_q.push_back({g ? 2'b10 : 2'b01, g ? 32'hBBBB_0002 : 32'hAAAA_0001, 1'b0, g});
            serve_op(1'b1, 4, g, 1, 2'b11, 8'h00);
        end

        // ---- write from requester 1 ----
        req_valid = 2'b10;
        req_op    = 2'b10;
        req_addr  = {32'hDEAD_0001, 32'hAAAA_0001};
        req_wdata = {8'hA5, 8'h3C};
        acc_q.push_back({2'b10, 32'hDEAD_0001, 1'b1, 1'b1});
        serve_op(1'b0, 3, 1'b1, 1, 2'b00, 8'hA5);
        req_wdata[15:8] = 8'h5A;
        #1;
        chk("wr_mux_comb", 64'(sd_outgoing_byte), 64'h5A);
        chk("wr_opcode_held", 64'(sd_op_code), 64'd1);

        // ---- async reset in the middle of a read ----
        req_addr  = {32'hDEAD_0001, 32'h0000_0777};
        req_op    = 2'b00;
        req_valid = 2'b01;
        acc_q.push_back({2'b01, 32'h0000_0777, 1'b0, 1'b0});
        tick();
        chk("arst_exec", 64'(sd_execute), 64'd1);
        req_valid = 2'b00;
        sd_busy   = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_finished_byte = 1'b1;
            sd_incoming_byte = i[7:0];
            rd_q.push_back({i[8:0], i[7:0]});
            tick();
        end
        sd_finished_byte = 1'b0;
        tick();
        chk("arst_pre_index", 64'(rd_index), 64'd99);
        #2;
        rst     = 1'b1;
        sd_busy = 1'b0;
        #1;
        chk("arst_ctrl", 64'({sd_execute, sd_op_code, sd_block_address}), 64'd0);
        chk("arst_rd", 64'({rd_data, rd_index, rd_valid}), 64'd0);
        chk("arst_status", 64'({grant_id, fault, ready, req_accept, done}), 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = 2'b01;
        repeat (5) tick();
        chk("arst_waits_busy", 64'({ready, sd_execute}), 64'd0);
        req_valid = 2'b00;
        sd_busy   = 1'b1;
        tick();
        sd_busy = 1'b0;
        tick();
        chk("arst_reinit_ready", 64'(ready), 64'd1);

        // ---- timeout on the short-watchdog instance ----
        rst_t     = 1'b0;
        sd_busy_t = 1'b1;
        tick();
        sd_busy_t = 1'b0;
        tick();
        chk("t_ready", 64'(ready_t), 64'd1);
        req_valid_t = 2'b01;
        acc_t_q.push_back({2'b01, 32'h0000_0777, 1'b0, 1'b0});
        n = 0;
        while (!sd_execute_t && n < 10) begin
            tick();
            n++;
        end
        chk("t_exec_seen", 64'(sd_execute_t), 64'd1);
        to_q.push_back(cyc + 50);
        sd_busy_t = 1'b1;
        n = 0;
        while (!timeout_err_t && n < 100) begin
            tick();
            n++;
        end
        chk("t_latency", 64'(n), 64'd50);
        chk("t_fault_set", 64'({fault_t, sd_execute_t, ready_t}), 64'b100);
        tick();
        chk("t_pulse_once", 64'({timeout_err_t, fault_t}), 64'b01);
        sd_busy_t = 1'b0;
        repeat (30) tick();
        chk("t_no_grant_in_fault", 64'({ready_t, sd_execute_t}), 64'd0);
        rst_t = 1'b1;
        #1;
        chk("t_fault_cleared", 64'(fault_t), 64'd0);

        // ---- drain check ----
        tick();
        @(negedge clk);
        #1;
        chk("q_accept_empty", 64'(acc_q.size()), 64'd0);
        chk("q_rd_empty", 64'(rd_q.size()), 64'd0);
        chk("q_done_empty", 64'(done_q.size()), 64'd0);
        chk("q_t_accept_empty", 64'(acc_t_q.size()), 64'd0);
        chk("q_timeout_empty", 64'(to_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
